// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit sitting beside the EX-stage ALU.
// Multiplies use radix-2 shift-add over operand magnitudes. Divides use restoring
// division over magnitudes. Both run 32 iterations. Divide-by-zero and signed
// overflow skip the iterations and load the architectural result directly.
// The sign fix is a single 64-bit negation. It is evaluated while the FSM sits in
// DONE and is registered into `out` together with the `done` pulse, so it never
// lengthens the iteration path.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            ready_o,
    output logic            done,
    output logic [XLEN-1:0] out
);

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    // Architectural state
    state_e              state;
    op_e                 op_q;
    logic [2*XLEN-1:0]   acc;          // MUL: {partial high, multiplier}; DIV: {remainder, quotient}
    logic [XLEN-1:0]     operand_mag;  // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic                neg_q;        // negate the selected result during DONE
    logic [4:0]          count;

    // Decode of the incoming request
    op_e                 op_in;
    logic                is_div_in;
    logic                is_rem_in;
    logic                signed_a_in;
    logic                signed_b_in;
    logic                sign_a;
    logic                sign_b;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic                neg_in;
    logic                div_by_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     special_res;

    // Iteration datapath
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic                div_ge;
    logic [XLEN-1:0]     div_sub;
    logic [2*XLEN-1:0]   div_next;

    // Result select and sign fix
    logic [XLEN-1:0]     div_sel;
    logic [2*XLEN-1:0]   fix_src;
    logic [2*XLEN-1:0]   fix_val;
    logic [XLEN-1:0]     result;

    // Request decode: operand signedness, magnitudes, result sign, special divides
    always_comb begin
        // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
        op_in       = op_e'(op);
        is_div_in   = op[2];
        is_rem_in   = op[2] & op[1];
        signed_a_in = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                      (op_in == OP_DIV)  || (op_in == OP_REM);
        signed_b_in = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        sign_a      = signed_a_in & operand_a[XLEN-1];
        sign_b      = signed_b_in & operand_b[XLEN-1];
        mag_a       = sign_a ? (XLEN'(0) - operand_a) : operand_a;
        mag_b       = sign_b ? (XLEN'(0) - operand_b) : operand_b;
        // The remainder follows the dividend; products and quotients follow the sign xor.
        neg_in      = is_rem_in ? sign_a : (sign_a ^ sign_b);
        div_by_zero = (operand_b == '0);
        div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (operand_a == INT_MIN) && (operand_b == ALL_ONES);
        special_res = '0;
        if (div_by_zero) begin
            special_res = is_rem_in ? operand_a : ALL_ONES;
        end else if (div_ovf) begin
            special_res = is_rem_in ? '0 : INT_MIN;
        end
    end

    // One shift-add step and one restoring-divide step over the shared accumulator
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand_mag} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        // acc[63:31] is the remainder shifted left with the next dividend bit brought in.
        div_ge   = (acc[2*XLEN-1:XLEN-1] >= {1'b0, operand_mag});
        div_sub  = acc[2*XLEN-2:XLEN-1] - operand_mag;
        div_next = div_ge ? {div_sub, acc[XLEN-2:0], 1'b1}
                          : {acc[2*XLEN-2:0], 1'b0};
    end

    // Final result: pick quotient/remainder or full product, apply the single negation, pick half
    always_comb begin
        div_sel = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        fix_src = op_q[2] ? {{XLEN{1'b0}}, div_sel} : acc;
        fix_val = neg_q ? ((2*XLEN)'(0) - fix_src) : fix_src;
        result  = ((op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_MULHU))
                  ? fix_val[2*XLEN-1:XLEN] : fix_val[XLEN-1:0];
    end

    // Control FSM, iteration registers and registered outputs
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
        if (rst) begin
            // NOTE: datapath registers are reset as well so `out` reads zero after reset.
            state       <= S_IDLE;
            op_q        <= OP_MUL;
            acc         <= '0;
            operand_mag <= '0;
            neg_q       <= 1'b0;
            count       <= '0;
            ready_o     <= 1'b1;
            done        <= 1'b0;
            out         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A flush in the same cycle cancels the request.
                    if (valid_i && !flush) begin
                        op_q    <= op_in;
                        count   <= 5'd31;
                        neg_q   <= neg_in;
                        ready_o <= 1'b0;
                        if (!is_div_in) begin
                            acc         <= {{XLEN{1'b0}}, mag_b};
                            operand_mag <= mag_a;
                            state       <= S_MUL;
                        end else if (div_by_zero || div_ovf) begin
                            // Both halves hold the answer, so either select path returns it.
                            acc         <= {special_res, special_res};
                            operand_mag <= mag_b;
                            neg_q       <= 1'b0;
                            state       <= S_DONE;
                        end else begin
                            acc         <= {{XLEN{1'b0}}, mag_a};
                            operand_mag <= mag_b;
                            state       <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state   <= S_IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        acc   <= mul_next;
                        count <= count - 5'd1;
                        if (count == 5'd0) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state   <= S_IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        acc   <= div_next;
                        count <= count - 5'd1;
                        if (count == 5'd0) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b1;
                    if (!flush) begin
                        done <= 1'b1;
                        out  <= result;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit,
// covering latency, special divides, flush, busy-time requests and mid-op reset.
module tb_muldiv_unit;

    localparam logic [2:0] MUL    = 3'd0;
    localparam logic [2:0] MULH   = 3'd1;
    localparam logic [2:0] MULHSU = 3'd2;
    localparam logic [2:0] MULHU  = 3'd3;
    localparam logic [2:0] DIV    = 3'd4;
    localparam logic [2:0] DIVU   = 3'd5;
    localparam logic [2:0] REM    = 3'd6;
    localparam logic [2:0] REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        ready_o;
    logic        done;
    logic [31:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .ready_o   (ready_o),
        .done      (done),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts done pulses over a window; none are expected.
    task automatic watch_no_done(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) pulses++;
        end
        check(tag, pulses, 0);
    endtask

    // Issues one op from a negedge, measures edges from accept to visible done,
    // checks latency, result and pulse width. With busy set, valid_i stays high
    // and operands/op keep changing until done appears.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input bit busy);
        int lat = 0;
        check({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
        valid_i   = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        @(negedge clk);
        if (!busy) valid_i = 1'b0;
        operand_a = ~a;
        operand_b = b + 32'd3;
        do begin
            tick();
            lat++;
            if (busy && !done) begin
                op        = DIVU;
                operand_a = 32'(lat * 3 + 1);
                operand_b = 32'(lat + 9);
            end
        end while (!done && lat < 100);
        valid_i = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_out"}, out, exp);
        tick();
        check({tag, "_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        valid_i   = 1'b0;
        flush     = 1'b0;
        op        = MUL;
        operand_a = 32'd0;
        operand_b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'b0, ready_o}, 32'd1);
        check("reset_done",  {31'b0, done},    32'd0);
        check("reset_out",   out,              32'd0);
        rst = 1'b0;
        tick();

        run_op("mul_7_m3",     MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
        run_op("mulh_min",     MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
        run_op("mulhu_max",    MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
        run_op("mulhsu_m1",    MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
        run_op("div_m7_2",     DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
        run_op("rem_m7_2",     REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
        run_op("div_7_m2",     DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 1'b0);
        run_op("rem_7_m2",     REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33, 1'b0);
        run_op("divu_100_7",   DIVU,   32'd100,      32'd7,        32'd14,       33, 1'b0);
        run_op("remu_100_7",   REMU,   32'd100,      32'd7,        32'd2,        33, 1'b0);
        run_op("divu_max_1",   DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, 1'b0);

        run_op("rem_5_0",      REM,    32'd5,        32'd0,        32'd5,        1,  1'b0);
        run_op("div_ovf",      DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
        run_op("rem_ovf",      REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1'b0);
        run_op("divu_5_0",     DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0);

        // Flush ten cycles into a divide: no pulse, out keeps the last result.
        valid_i   = 1'b1;
        op        = DIVU;
        operand_a = 32'd100;
        operand_b = 32'd7;
        tick();
        valid_i = 1'b0;
        check("flush_busy", {31'b0, ready_o}, 32'd0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready", {31'b0, ready_o}, 32'd1);
        check("flush_done",  {31'b0, done},    32'd0);
        check("flush_out",   out,              32'hFFFFFFFF);
        watch_no_done("flush_no_done", 40);
        check("flush_out_held", out, 32'hFFFFFFFF);

        // Flush together with valid in IDLE: no accept.
        valid_i   = 1'b1;
        flush     = 1'b1;
        op        = MUL;
        operand_a = 32'd2;
        operand_b = 32'd2;
        tick();
        valid_i = 1'b0;
        flush   = 1'b0;
        check("idle_flush_ready", {31'b0, ready_o}, 32'd1);
        watch_no_done("idle_flush_no_done", 40);

        run_op("mul_3_4", MUL, 32'd3, 32'd4, 32'd12, 33, 1'b0);

        // Requests while busy are ignored; only the first op completes.
        run_op("busy_mul", MUL, 32'd5, 32'd6, 32'd30, 33, 1'b1);
        watch_no_done("busy_no_extra", 40);
        check("busy_ready", {31'b0, ready_o}, 32'd1);

        // Reset mid-multiply.
        valid_i   = 1'b1;
        op        = MUL;
        operand_a = 32'd3;
        operand_b = 32'd4;
        tick();
        valid_i = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ready", {31'b0, ready_o}, 32'd1);
        check("rst_mid_done",  {31'b0, done},    32'd0);
        check("rst_mid_out",   out,              32'd0);
        watch_no_done("rst_mid_no_done", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
